// File: rtl/muldiv_unit_if.sv
// ============================================================================
//  Module      : muldiv_unit_if
//  Description : Request/response bundle between the issue stage and the
//                iterative RV32M multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    // Issue side: drives requests, observes completion.
    modport master (
        output start, funct3, operand_a, operand_b, rd_in,
        input  busy, done, result, rd_out
    );

    // Execute side: the multiply/divide unit itself.
    modport slave (
        input  start, funct3, operand_a, operand_b, rd_in,
        output busy, done, result, rd_out
    );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative RV32M execute unit (MUL/MULH/MULHSU/MULHU/DIV/
//                DIVU/REM/REMU). Shift-add multiply and restoring divide on
//                operand magnitudes, followed by a sign-fixup cycle.
//                Optional macro MULDIV_FAST_MUL_EN: multiplies complete
//                combinationally in the accept cycle; divides stay iterative.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  wire           clk,
    input  wire           rst_n,
    muldiv_unit_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [5:0]      C_LAST    = 6'(XLEN - 1);
    localparam logic [XLEN-1:0] C_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state_q,  state_d;
    logic [5:0]      cnt_q,    cnt_d;
    logic [2:0]      op_q,     op_d;
    logic [4:0]      rd_q,     rd_d;
    logic            sa_q,     sa_d;
    logic            sb_q,     sb_d;
    logic [XLEN-1:0] acc_q,    acc_d;     // product high half / partial remainder
    logic [XLEN-1:0] lo_q,     lo_d;      // multiplier bits / dividend-quotient
    logic [XLEN-1:0] opb_q,    opb_d;     // multiplicand / divisor magnitude
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_out_q, rd_out_d;

    logic            w_accept;
    logic            w_sa_en, w_sb_en, w_sa, w_sb;
    logic [XLEN-1:0] w_a_mag, w_b_mag;
    logic            w_special;
    logic [XLEN-1:0] w_spec_res;
    logic [XLEN:0]   w_mul_sum;
    logic [XLEN:0]   w_div_shift;
    logic            w_div_borrow;
    logic [XLEN-1:0] w_div_diff;
    logic [2*XLEN-1:0] w_prod, w_prod_fix;
    logic [XLEN-1:0] w_quot_fix, w_rem_fix, w_fix_res;

    assign bus.busy   = (state_q == S_CALC) || (state_q == S_FIXUP);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;

    // Operand sign decode, magnitudes and the bypass (special-case) results.
    always_comb begin
        w_accept = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
        w_sa_en  = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                   (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        w_sb_en  = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                   (bus.funct3 == 3'b110);
        w_sa     = w_sa_en && bus.operand_a[XLEN-1];
        w_sb     = w_sb_en && bus.operand_b[XLEN-1];
        w_a_mag  = w_sa ? (-bus.operand_a) : bus.operand_a;
        w_b_mag  = w_sb ? (-bus.operand_b) : bus.operand_b;

        w_special  = 1'b0;
        w_spec_res = '0;
        if (bus.funct3[2]) begin
            if (bus.operand_b == '0) begin
                w_special  = 1'b1;
                w_spec_res = bus.funct3[1] ? bus.operand_a : {XLEN{1'b1}};
            end else if (!bus.funct3[0] && (bus.operand_a == C_INT_MIN) &&
                         (&bus.operand_b)) begin
                w_special  = 1'b1;
                w_spec_res = bus.funct3[1] ? '0 : C_INT_MIN;
            end
        end
`ifdef MULDIV_FAST_MUL_EN
        else begin
            // Sign-extended operands give the signed/unsigned product directly.
            w_special  = 1'b1;
            w_prod     = {{XLEN{w_sa_en & bus.operand_a[XLEN-1]}}, bus.operand_a} *
                         {{XLEN{w_sb_en & bus.operand_b[XLEN-1]}}, bus.operand_b};
            w_spec_res = (bus.funct3[1:0] == 2'b00) ? w_prod[XLEN-1:0]
                                                    : w_prod[2*XLEN-1:XLEN];
        end
`endif
    end

    // One iteration of shift-add multiply and restoring divide.
    always_comb begin
        w_mul_sum    = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        w_div_shift  = {acc_q, lo_q[XLEN-1]};
        w_div_borrow = w_div_shift < {1'b0, opb_q};
        w_div_diff   = w_div_shift[XLEN-1:0] - opb_q;
    end

    // Sign correction of the finished product / quotient / remainder.
    always_comb begin
        w_prod_fix = (sa_q ^ sb_q) ? (-{acc_q, lo_q}) : {acc_q, lo_q};
        w_quot_fix = (sa_q ^ sb_q) ? (-lo_q) : lo_q;
        w_rem_fix  = sa_q ? (-acc_q) : acc_q;
        if (op_q[2])
            w_fix_res = op_q[1] ? w_rem_fix : w_quot_fix;
        else
            w_fix_res = (op_q[1:0] == 2'b00) ? w_prod_fix[XLEN-1:0]
                                             : w_prod_fix[2*XLEN-1:XLEN];
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        case (state_q)
            S_CALC: begin
                if (op_q[2]) begin
                    acc_d = w_div_borrow ? w_div_shift[XLEN-1:0] : w_div_diff;
                    lo_d  = {lo_q[XLEN-2:0], ~w_div_borrow};
                end else begin
                    acc_d = w_mul_sum[XLEN:1];
                    lo_d  = {w_mul_sum[0], lo_q[XLEN-1:1]};
                end
                if (cnt_q == C_LAST) begin
                    cnt_d   = '0;
                    state_d = S_FIXUP;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_FIXUP: begin
                result_d = w_fix_res;
                rd_out_d = rd_q;
                state_d  = S_DONE;
            end
            default: begin  // S_IDLE and S_DONE both accept new work
                state_d = S_IDLE;
                if (w_accept) begin
                    op_d  = bus.funct3;
                    rd_d  = bus.rd_in;
                    sa_d  = w_sa;
                    sb_d  = w_sb;
                    cnt_d = '0;
                    acc_d = '0;
                    if (w_special) begin
                        result_d = w_spec_res;
                        rd_out_d = bus.rd_in;
                        state_d  = S_DONE;
                    end else begin
                        lo_d    = bus.funct3[2] ? w_a_mag : w_b_mag;
                        opb_d   = bus.funct3[2] ? w_b_mag : w_a_mag;
                        state_d = S_CALC;
                    end
                end
            end
        endcase
    end

    // State registers with asynchronous reset that aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            acc_q    <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Self-checking bench for muldiv_unit: table of operations
//                with a result scoreboard, plus ignored-start, back-to-back
//                and mid-operation reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;
`ifdef MULDIV_FAST_MUL_EN
    localparam int ML = 0;
`else
    localparam int ML = 33;
`endif
    localparam int NV = 20;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    exp_t sb_q[$];
    vec_t tbl[NV];

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Drive a request (caller is between edges); returns just after E0.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int lat);
        exp_t e;
        bus.funct3    = f;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.rd_in     = rd;
        bus.start     = 1'b1;
        e.res = exp;
        e.rd  = rd;
        e.lat = lat;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Count edges after E0 until done; optionally pulse a stray start at edge inj.
    task automatic wait_done(input string tag, input int inj);
        exp_t e;
        int   k;
        int   got;
        bit   busy_ok;
        e       = sb_q.pop_front();
        k       = 0;
        got     = -1;
        busy_ok = 1'b1;
        while (k <= 40) begin
            if (bus.done) begin
                got = k;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
            if (inj > 0 && k == inj - 1) begin
                bus.funct3    = 3'b101;
                bus.operand_a = 32'd1000;
                bus.operand_b = 32'd3;
                bus.rd_in     = 5'd9;
                bus.start     = 1'b1;
            end else if (inj > 0 && k == inj) begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, " latency"}, 64'(got), 64'(e.lat));
        if (e.lat == 0) check({tag, " busy"}, 64'(bus.busy), 64'd0);
        else            check({tag, " busy"}, 64'(busy_ok), 64'd1);
        check({tag, " result"}, 64'(bus.result), 64'(e.res));
        check({tag, " rd_out"}, 64'(bus.rd_out), 64'(e.rd));
    endtask

    // One edge after done: unit idle, outputs held.
    task automatic check_idle(input string tag, input logic [31:0] res, input logic [4:0] rd);
        @(posedge clk);
        #1;
        check({tag, " idle"}, {bus.done, bus.busy, bus.rd_out, bus.result},
              {1'b0, 1'b0, rd, res});
    endtask

    initial begin
        int ndone;
        n_checks = 0;
        n_fail   = 0;
        tbl[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, ML};
        tbl[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, ML};
        tbl[2]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFF, ML};
        tbl[3]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd8,  32'h4000_0000, ML};
        tbl[4]  = '{3'b001, 32'h0000_0007, 32'hFFFF_FFFD, 5'd9,  32'hFFFF_FFFF, ML};
        tbl[5]  = '{3'b000, 32'h1234_5678, 32'h0000_0010, 5'd10, 32'h2345_6780, ML};
        tbl[6]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd11, 32'hFFFF_FFFD, 33};
        tbl[7]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd12, 32'hFFFF_FFFF, 33};
        tbl[8]  = '{3'b101, 32'd100,       32'd7,         5'd13, 32'd14,        33};
        tbl[9]  = '{3'b111, 32'd100,       32'd7,         5'd14, 32'd2,         33};
        tbl[10] = '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 5'd15, 32'hFFFF_FFFD, 33};
        tbl[11] = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 5'd16, 32'h0000_0001, 33};
        tbl[12] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0000_0000, 33};
        tbl[13] = '{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, 33};
        tbl[14] = '{3'b101, 32'h1234_5678, 32'h0000_0000, 5'd19, 32'hFFFF_FFFF, 0};
        tbl[15] = '{3'b110, 32'h1234_5678, 32'h0000_0000, 5'd20, 32'h1234_5678, 0};
        tbl[16] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'h8000_0000, 0};
        tbl[17] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'h0000_0000, 0};
        tbl[18] = '{3'b100, 32'h8000_0000, 32'h0000_0002, 5'd23, 32'hC000_0000, 33};
        tbl[19] = '{3'b011, 32'h8000_0000, 32'h0000_0002, 5'd24, 32'h0000_0001, ML};

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.funct3    = 3'b000;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.rd_in     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {bus.done, bus.busy, bus.rd_out, bus.result}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            issue(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp, tbl[i].lat);
            wait_done($sformatf("vec%0d", i), 0);
            check_idle($sformatf("vec%0d", i), tbl[i].exp, tbl[i].rd);
        end

        // Stray start at E5 is ignored; then a start during DONE is accepted.
        issue(3'b101, 32'd100, 32'd7, 5'd3, 32'd14, 33);
        wait_done("ignored start", 5);
        issue(3'b101, 32'd1000, 32'd3, 5'd9, 32'd333, 33);
        wait_done("back-to-back", 0);
        check_idle("back-to-back", 32'd333, 5'd9);

        // Reset at E10 of a DIV aborts it with no done.
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 33);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort outputs", {bus.done, bus.busy, bus.rd_out, bus.result}, 64'd0);
        void'(sb_q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        check("no stray done", 64'(ndone), 64'd0);
        issue(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd12, 32'hFFFF_FFEB, ML);
        wait_done("post-reset mul", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M execute unit for MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Sits directly downstream of the register file:
  - consumes the two source values (read_data_1 / read_data_2) plus the destination index;
  - produces a result and index that feed the register file write port (write_data / address_3 / write_enable).
- Multi-cycle with start/busy/done handshake; the core stalls while busy.

Parameters:
- XLEN, 32, operand/result width. Iteration count equals XLEN. Only 32 is supported for RV32IM; the RTL is still written width-generic.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on the rising edge of clk.
- funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_a  input  XLEN  rs1 value (multiplicand / dividend).
- operand_b  input  XLEN  rs2 value (multiplier / divisor).
- rd_in  input  5  destination register index.
- busy  output  1  operation in flight; new starts ignored.
- done  output  1  one-cycle pulse; result and rd_out valid.
- result  output  XLEN  operation result.
- rd_out  output  5  destination index for the completed op; connects to the register file write address.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst_n is asynchronous and active-low.
  - Reset values: state=IDLE, busy=0, done=0, result=0, rd_out=0, internal counters/accumulators=0.
  - Reset asserted mid-operation aborts the op immediately. No done is issued for it.
- States:
  - IDLE: waiting.
  - CALC: XLEN iterations.
  - FIXUP: sign correction and result select.
  - DONE: done=1 for exactly one cycle.
- Outputs by state:
  - busy=1 in CALC and FIXUP only.
  - done=1 in DONE only.
- Start acceptance:
  - start is accepted only in IDLE or DONE. Back-to-back issue is allowed: start seen in DONE is accepted.
  - start while busy=1 is ignored. Latched operands, funct3 and rd are unaffected.
  - On accept, latch funct3, rd_in, operand magnitudes and sign flags.
- Sign handling:
  - Signed inputs are MULH (a, b), MULHSU (a only), DIV/REM (a, b).
  - Magnitude = two's-complement absolute value. abs(0x80000000) = 0x80000000, treated as unsigned.
- Multiply: unsigned shift-add over XLEN iterations into a 2*XLEN product.
  - FIXUP negates the product if the operand signs differ (signed operands only).
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
  - MUL result is identical for all sign interpretations.
- Divide: restoring radix-2 over XLEN iterations on magnitudes.
  - Signed quotient is negated if the signs differ.
  - Signed remainder takes the sign of the dividend.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases (bypass CALC and go straight to DONE):
  - Divisor=0: quotient=0xFFFFFFFF (DIV and DIVU); remainder=operand_a.
  - Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): quotient=0x80000000, remainder=0.
- Latency, counted from edge E0 that samples start:
  - Normal: E0 enters CALC; E1..E32 iterate; E33 performs FIXUP, enters DONE and raises done. Done is high from E33 to E34.
  - Special case: E0 enters DONE with result loaded; done is high from E0 to E1.
- Holding: result and rd_out update only on entry to DONE and hold until the next completion.
- Iteration counter: 6-bit, counts 0..31. Terminal count moves CALC to FIXUP; no wrap past 31.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - All MUL* ops compute combinationally (full 33x33 signed product) and take the special-case path: done on E0, busy never asserted.
  - Division is unchanged.
- Undefined:
  - Multiply uses the iterative path with 33-edge latency.
  - No combinational multiplier is instantiated.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3) -> result 0xFFFFFFEB, rd_out=rd_in, done one cycle at E33 (E0 with MULDIV_FAST_MUL_EN).
- MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF. MULH a=0x80000000, b=0x80000000 -> 0x40000000.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM -> 0xFFFFFFFF. DIVU a=100, b=7 -> 14. REMU -> 2. Each op: done at E33, busy high E0..E33.
- DIVU a=0x12345678, b=0 -> 0xFFFFFFFF. REM same operands -> 0x12345678. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000. REM -> 0. All with done on E0, busy never high.
- Start a DIVU, pulse start with different operands/rd at E5 -> ignored; original result and rd_out at E33. Issue a new start during DONE -> accepted, done again 33 edges later.
- Drop rst_n low at E10 of a DIV -> busy, done, result, rd_out go to 0 immediately. After release, no stray done. A new MUL completes normally.
